// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-fed UART transmitter, LSB first, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [DATA_BITS-1:0]            wr_data,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            busy,
  output logic                            tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count_next;
  logic                 push;
  logic                 pop;

  state_t               state;
  state_t               state_next;
  logic [BW-1:0]        baud;
  logic [BW-1:0]        baud_next;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        idx_next;
  logic                 stop_idx;
  logic                 stop_idx_next;
  logic [DATA_BITS-1:0] sh;
  logic [DATA_BITS-1:0] sh_next;
  logic                 tx_next;
  logic                 bit_end;
  logic                 stop_end;

  assign bit_end  = baud == BAUD_LAST;
  assign stop_end = bit_end && (STOP_BITS == 1 || stop_idx);

  // Uses the pre-edge full flag, so a write while full is lost even on a pop.
  assign push = wr_en && !full;
  assign pop  = !empty &&
                (state == S_IDLE || (state == S_STOP && stop_end));

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      empty <= count_next == '0;
      full  <= count_next == DEPTH;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic par;

  always_ff @(posedge clock) begin
    if (reset)    par <= 1'b0;
    else if (pop) par <= (^mem[rd_ptr]) ^ 1'(PARITY_ODD);
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      baud     <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      sh       <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      baud     <= baud_next;
      idx      <= idx_next;
      stop_idx <= stop_idx_next;
      sh       <= sh_next;
      tx       <= tx_next;
    end
  end

  always_comb begin
    state_next    = state;
    baud_next     = bit_end ? '0 : baud + BW'(1);
    idx_next      = idx;
    stop_idx_next = stop_idx;
    sh_next       = sh;
    unique case (state)
      S_IDLE: begin
        baud_next = '0;
        if (pop) begin
          state_next = S_START;
          sh_next    = mem[rd_ptr];
        end
      end
      S_START: begin
        if (bit_end) begin
          state_next = S_DATA;
          idx_next   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          sh_next  = sh >> 1;
          idx_next = idx + IW'(1);
          if (idx == IDX_LAST) begin
            stop_idx_next = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_next    = S_STOP;
          stop_idx_next = 1'b0;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) stop_idx_next = ~stop_idx;
        // Back-to-back frames: reload straight into START.
        if (stop_end) begin
          if (pop) begin
            state_next = S_START;
            sh_next    = mem[rd_ptr];
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_next = 1'b1;
    busy    = state != S_IDLE;
    unique case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = sh_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_next = par;
`endif
      default:  tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, FIFO flags, reset abort.
// A second instance with two stop bits covers the longer stop period.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL1 = (1 + DB + PB + 1) * CPB;
  localparam int FL2 = (1 + DB + PB + 2) * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic       wr_en2 = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] wr_data2 = '0;
  logic       full, empty, busy, tx;
  logic [2:0] count;
  logic       full2, empty2, busy2, tx2;
  logic [2:0] count2;

  int checks = 0;
  int errors = 0;
  logic       q1[$];
  logic       q2[$];
  logic [7:0] exp_q[$];

  uart_tx_fifo #(
    .DATA_BITS(DB), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4),
    .STOP_BITS(1), .PARITY_ODD(0)
  ) u_dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .busy(busy), .tx(tx)
  );

  uart_tx_fifo #(
    .DATA_BITS(DB), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4),
    .STOP_BITS(2), .PARITY_ODD(0)
  ) u_dut2 (
    .clock(clock), .reset(reset), .wr_en(wr_en2), .wr_data(wr_data2),
    .full(full2), .empty(empty2), .count(count2), .busy(busy2), .tx(tx2)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    q1.push_back(tx);
    q2.push_back(tx2);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [63:0] wave(input logic [7:0] d);
    logic [15:0] b;
    logic [63:0] w;
    b      = '1;
    b[0]   = 1'b0;
    b[8:1] = d;
`ifdef UART_TX_PARITY_EN
    b[9]   = ^d;
`endif
    for (int i = 0; i < 64; i++) w[i] = b[i / CPB];
    return w;
  endfunction

  function automatic int first_low(input int sel);
    int st;
    st = -1;
    if (sel == 0) begin
      foreach (q1[i]) if (st < 0 && q1[i] == 1'b0) st = i;
    end else begin
      foreach (q2[i]) if (st < 0 && q2[i] == 1'b0) st = i;
    end
    return st;
  endfunction

  task automatic chk_stream(input string tag, input int sel, input int fl);
    logic       s[$];
    logic [63:0] w;
    logic [7:0] got;
    int st, bad, p, stop;
    if (sel == 0) s = q1;
    else          s = q2;
    st = first_low(sel);
    chk({tag, "_start"}, 32'(st >= 0), 1);
    if (st < 0) return;
    for (int k = 0; k < exp_q.size(); k++) begin
      w   = wave(exp_q[k]);
      bad = 0;
      got = '0;
      for (int i = 0; i < fl; i++) begin
        p = st + k * fl + i;
        if (p >= s.size() || s[p] !== w[i]) bad++;
      end
      for (int j = 0; j < 8; j++) begin
        p = st + k * fl + (1 + j) * CPB + CPB / 2;
        if (p < s.size()) got[j] = s[p];
      end
      chk($sformatf("%s_data%0d", tag, k), got, exp_q[k]);
      chk($sformatf("%s_wave%0d", tag, k), bad, 0);
    end
    stop = st + exp_q.size() * fl;
    bad  = (s.size() < stop + 4) ? 1 : 0;
    for (int i = stop; i < s.size(); i++) if (s[i] !== 1'b1) bad++;
    chk({tag, "_tail"}, bad, 0);
  endtask

  task automatic wait_idle(input string tag, input int sel, input int maxc);
    int n;
    n = 0;
    while (n < maxc &&
           (sel == 0 ? (busy || !empty) : (busy2 || !empty2))) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < maxc), 1);
    cyc(8);
  endtask

  initial begin
    int n, st, run, zeros, busys;

    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_tx2", tx2, 1);

    // Basic frame and write-to-start latency
    q1.delete();
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clock);
    wr_en = 1'b0;
    chk("lat_tx_n", tx, 1);
    chk("lat_count_n", count, 1);
    chk("lat_empty_n", empty, 0);
    @(negedge clock);
    chk("lat_tx_n1", tx, 0);
    chk("lat_busy_n1", busy, 1);
    chk("pop_count", count, 0);
    chk("pop_empty", empty, 1);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clock);
    end
    chk("busy_len", n, FL1);
    cyc(6);
    exp_q = '{8'hA5};
    chk_stream("a5", 0, FL1);

    // Overflow: 0x06 lands while full and is dropped
    q1.delete();
    for (int d = 1; d <= 6; d++) begin
      wr_en = 1'b1; wr_data = 8'(d);
      @(negedge clock);
    end
    wr_en = 1'b0;
    chk("ovf_full", full, 1);
    chk("ovf_count", count, 4);
    wait_idle("ovf", 0, 1000);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    chk_stream("ovf", 0, FL1);

    // Two stop bits on the second instance
    q2.delete();
    wr_en2 = 1'b1; wr_data2 = 8'h3C;
    @(negedge clock);
    wr_data2 = 8'hC3;
    @(negedge clock);
    wr_en2 = 1'b0;
    wait_idle("stop2", 1, 1000);
    exp_q = '{8'h3C, 8'hC3};
    chk_stream("stop2", 1, FL2);
    st  = first_low(1);
    run = 0;
    if (st >= 0 && st + FL2 < q2.size()) begin
      for (int p = st + FL2 - 1; p > st && q2[p] == 1'b1; p--) run++;
    end
    chk("stop2_run", run, 8);

`ifdef UART_TX_PARITY_EN
    q1.delete();
    wr_en = 1'b1; wr_data = 8'h07;
    @(negedge clock);
    wr_en = 1'b0;
    wait_idle("par", 0, 500);
    st = first_low(0);
    chk("par_bit", (st >= 0) ? q1[st + 9 * CPB + 2] : 1'bx, 1);
    exp_q = '{8'h07};
    chk_stream("par", 0, FL1);
`endif

    // Reset during data bit 3 with two words queued
    for (int d = 0; d < 3; d++) begin
      wr_en = 1'b1; wr_data = 8'h11 * 8'(d + 1);
      @(negedge clock);
    end
    wr_en = 1'b0;
    chk("mid_count", count, 2);
    cyc(16);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_tx", tx, 1);
    chk("mid_busy", busy, 0);
    chk("mid_count0", count, 0);
    chk("mid_empty", empty, 1);
    zeros = 0;
    busys = 0;
    repeat (150) begin
      @(negedge clock);
      if (tx !== 1'b1) zeros++;
      if (busy !== 1'b0) busys++;
    end
    chk("mid_quiet_tx", zeros, 0);
    chk("mid_quiet_busy", busys, 0);

    // Write and pop on the same edge in the last stop cycle
    q1.delete();
    wr_en = 1'b1; wr_data = 8'h5A;
    @(negedge clock);
    wr_data = 8'h96;
    @(negedge clock);
    wr_en = 1'b0;
    chk("sim_count_idle", count, 1);
    cyc(FL1 - 1);
    wr_en = 1'b1; wr_data = 8'hE1;
    @(negedge clock);
    wr_en = 1'b0;
    chk("sim_count", count, 1);
    chk("sim_empty", empty, 0);
    chk("sim_tx", tx, 0);
    wait_idle("sim", 0, 500);
    exp_q = '{8'h5A, 8'h96, 8'hE1};
    chk_stream("sim", 0, FL1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
